// File: rtl/clock_ctrl_pkg.sv
// Shared types and defaults for the compute clock gate controller.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_STALLED = 3'd3,
        ST_RESUME  = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int DEF_RESUME_CYCLES = 2;
    localparam int DEF_CNT_W         = 48;
    localparam int TMR_W             = 8;

endpackage

// File: rtl/stall_arbiter.sv
// Fixed-priority, grant-locking one-hot arbiter; a released grant always
// leaves one idle cycle before the next grant.
module stall_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] lowest_s;
    logic [NUM_REQ-1:0] grant_next_s;

    // Lowest-index active request, one-hot.
    always_comb begin
        lowest_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lowest_s    = '0;
                lowest_s[i] = 1'b1;
            end else begin
                lowest_s = lowest_s;
            end
        end
    end

    // Hold while the owner keeps requesting; on release drop to zero first.
    always_comb begin
        grant_next_s = '0;
        if (!enable) begin
            grant_next_s = '0;
        end else if (grant != '0) begin
            grant_next_s = ((req & grant) != '0) ? grant : '0;
        end else begin
            grant_next_s = lowest_s;
        end
    end

    // Grant register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant <= '0;
        end else begin
            grant <= grant_next_s;
        end
    end

endmodule

// File: rtl/compute_clock_gate_ctrl.sv
// Sequencer for the compute clock buffer enable: bounded runs, settled stall
// handshakes, and enabled/stalled cycle accounting.
module compute_clock_gate_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int RESUME_CYCLES = DEF_RESUME_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               control_clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   cycle_budget,
    input  logic               halt,
    input  logic [NUM_REQ-1:0] stall_req,
    output logic [NUM_REQ-1:0] stall_ack,
    output logic               compute_clock_en_n,
    output logic               running,
    output logic               done,
    output logic [CNT_W-1:0]   virtual_cycles,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RESUME_LOAD = TMR_W'(RESUME_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO    = '0;
    localparam logic [TMR_W-1:0] TMR_ONE     = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_r, state_next_s;
    logic [TMR_W-1:0] tmr_r, tmr_next_s;
    logic             finishing_r, finishing_next_s;
    logic             from_run_r, from_run_next_s;
    logic [CNT_W-1:0] budget_r;
    logic             start_ok_s;
    logic             done_next_s;
    logic             req_any_s;
    logic             exhaust_s;

    assign req_any_s = |stall_req;
    assign exhaust_s = (virtual_cycles == (budget_r - CNT_ONE));

    // Next-state logic; a finish request outranks a stall request in RUN.
    always_comb begin
        state_next_s     = state_r;
        tmr_next_s       = tmr_r;
        finishing_next_s = finishing_r;
        from_run_next_s  = from_run_r;
        start_ok_s       = 1'b0;
        done_next_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (cycle_budget != CNT_ZERO) begin
                        state_next_s = ST_RUN;
                        start_ok_s   = 1'b1;
                    end else begin
                        done_next_s = 1'b1;
                    end
                end else if (req_any_s) begin
                    state_next_s    = ST_STALLED;
                    from_run_next_s = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (exhaust_s || halt) begin
                    state_next_s     = ST_DRAIN;
                    finishing_next_s = 1'b1;
                    tmr_next_s       = SETTLE_LOAD;
                end else if (req_any_s) begin
                    state_next_s = ST_DRAIN;
                    tmr_next_s   = SETTLE_LOAD;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (tmr_r != TMR_ZERO) begin
                    tmr_next_s = tmr_r - TMR_ONE;
                end else if (finishing_r) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s    = ST_STALLED;
                    from_run_next_s = 1'b1;
                end
            end
            ST_STALLED: begin
                // Exit only once every requester is quiet; otherwise the arbiter serves the next.
                if (req_any_s) begin
                    state_next_s = ST_STALLED;
                end else if (from_run_r) begin
                    state_next_s = ST_RESUME;
                    tmr_next_s   = RESUME_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RESUME: begin
                if (req_any_s) begin
                    state_next_s = ST_STALLED;
                end else if (tmr_r == TMR_ZERO) begin
                    state_next_s = ST_RUN;
                end else begin
                    tmr_next_s = tmr_r - TMR_ONE;
                end
            end
            ST_FINISH: begin
                state_next_s     = ST_IDLE;
                finishing_next_s = 1'b0;
                done_next_s      = 1'b1;
            end
            default: begin
                state_next_s     = ST_IDLE;
                finishing_next_s = 1'b0;
            end
        endcase
    end

    // State, timer, flags and all registered outputs.
    always_ff @(posedge control_clock) begin
        if (!reset_n) begin
            state_r            <= ST_IDLE;
            tmr_r              <= TMR_ZERO;
            finishing_r        <= 1'b0;
            from_run_r         <= 1'b0;
            budget_r           <= CNT_ZERO;
            compute_clock_en_n <= 1'b1;
            running            <= 1'b0;
            done               <= 1'b0;
            virtual_cycles     <= CNT_ZERO;
            stall_cycles       <= CNT_ZERO;
        end else begin
            state_r            <= state_next_s;
            tmr_r              <= tmr_next_s;
            finishing_r        <= finishing_next_s;
            from_run_r         <= from_run_next_s;
            compute_clock_en_n <= (state_next_s != ST_RUN);
            running            <= (state_next_s == ST_RUN);
            done               <= done_next_s;
            if (start_ok_s) begin
                budget_r       <= cycle_budget;
                virtual_cycles <= CNT_ZERO;
                stall_cycles   <= CNT_ZERO;
            end else begin
                if ((state_r == ST_RUN) && (virtual_cycles != CNT_MAX)) begin
                    virtual_cycles <= virtual_cycles + CNT_ONE;
                end
                if (((state_r == ST_DRAIN) || (state_r == ST_STALLED) || (state_r == ST_RESUME))
                    && !finishing_r && (stall_cycles != CNT_MAX)) begin
                    stall_cycles <= stall_cycles + CNT_ONE;
                end
            end
        end
    end

    stall_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (control_clock),
        .reset_n (reset_n),
        .enable  (state_next_s == ST_STALLED),
        .req     (stall_req),
        .grant   (stall_ack)
    );

endmodule
